// File: rtl/floating_point_divider_seq.sv
// Sequential restoring floating-point divider, one quotient bit per cycle.
// Define FP_DIV_EARLY_EXIT_EN to finish early on an exact zero remainder.
module result_rounder #(
    parameter int MANTISSA_WIDTH   = 23,
    parameter int ROUND_TO_NEAREST = 1
) (
    input  logic [MANTISSA_WIDTH-1:0] i_mant,
    input  logic                      i_guard,
    input  logic                      i_sticky,
    output logic [MANTISSA_WIDTH-1:0] o_mant,
    output logic                      o_carry
);
    logic w_inc;

    // Ties go to the even mantissa
    assign w_inc = (ROUND_TO_NEAREST != 0) && i_guard && (i_sticky || i_mant[0]);
    assign {o_carry, o_mant} = {1'b0, i_mant} + {{MANTISSA_WIDTH{1'b0}}, w_inc};
endmodule

module floating_point_divider_seq #(
    parameter int EXPONENT_WIDTH   = 8,
    parameter int MANTISSA_WIDTH   = 23,
    parameter int ROUND_TO_NEAREST = 1,
    parameter int ROUNDING_BITS    = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
    output logic                                   underflow_flag,
    output logic                                   overflow_flag,
    output logic                                   invalid_operation_flag,
    output logic                                   divide_by_zero_flag
);
    localparam int EW  = EXPONENT_WIDTH;
    localparam int MW  = MANTISSA_WIDTH;
    localparam int W   = EW + MW + 1;
    localparam int TRB = ROUNDING_BITS * ROUND_TO_NEAREST;
    localparam int Q   = MW + TRB + 2;
    localparam int CW  = $clog2(Q + 1);
    localparam int XW  = EW + 2;
    localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EW - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);
    localparam logic [Q-2:0]  LOW_MASK = (Q-1)'((1 << TRB) - 1);
    localparam logic [MW-1:0] QNAN_M   = (EW == 4 && MW == 3) ?
        {MW{1'b1}} : {1'b1, {(MW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [MW+1:0]         r_rem;
    logic [MW:0]           r_div;
    logic [Q-1:0]          r_quo;
    logic signed [XW-1:0]  r_exp;
    logic                  r_sign;
    logic [W-1:0]          r_out;
    logic                  r_uf, r_of, r_inv, r_dbz;

    // Operand classification
    logic w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic w_snan_a, w_snan_b, w_special, w_sign;
    logic [W-1:0] w_sp_out;
    logic w_sp_inv, w_sp_dbz;

    assign w_sign   = a[W-1] ^ b[W-1];
    assign w_zero_a = (a[W-2:MW] == '0);
    assign w_zero_b = (b[W-2:MW] == '0);
    assign w_inf_a  = (a[W-2:MW] == '1) && (a[MW-1:0] == '0);
    assign w_inf_b  = (b[W-2:MW] == '1) && (b[MW-1:0] == '0);
    assign w_nan_a  = (a[W-2:MW] == '1) && (a[MW-1:0] != '0);
    assign w_nan_b  = (b[W-2:MW] == '1) && (b[MW-1:0] != '0);
    assign w_snan_a = w_nan_a && !a[MW-1];
    assign w_snan_b = w_nan_b && !b[MW-1];
    assign w_special = w_zero_a || w_zero_b || w_inf_a || w_inf_b || w_nan_a || w_nan_b;

    always_comb begin
        w_sp_out = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
        w_sp_inv = 1'b0;
        w_sp_dbz = 1'b0;
        if (w_nan_a || w_nan_b) begin
            w_sp_out = {1'b1, {EW{1'b1}}, QNAN_M};
            w_sp_inv = w_snan_a || w_snan_b;
        end else if ((w_zero_a && w_zero_b) || (w_inf_a && w_inf_b)) begin
            w_sp_out = {1'b1, {EW{1'b1}}, QNAN_M};
            w_sp_inv = 1'b1;
        end else if (w_zero_b) begin
            w_sp_dbz = 1'b1;
        end else if (!w_inf_a) begin
            w_sp_out = {w_sign, {(W-1){1'b0}}};
        end
    end

    // One restoring step
    logic [MW+2:0] w_diff;
    logic          w_ge;
    logic [MW:0]   w_rem_sel;
    logic [Q-1:0]  w_quo_nxt;

    assign w_diff    = {1'b0, r_rem} - {2'b00, r_div};
    assign w_ge      = !w_diff[MW+2];
    assign w_rem_sel = w_ge ? w_diff[MW:0] : r_rem[MW:0];
    assign w_quo_nxt = {r_quo[Q-2:0], w_ge};

    // Normalization and rounding
    logic [Q-2:0]         w_qn;
    logic signed [XW-1:0] w_exp_n, w_exp_r;
    logic [MW-1:0]        w_rmant;
    logic                 w_carry, w_sticky;

    assign w_qn     = r_quo[Q-1] ? r_quo[Q-2:0] : {r_quo[Q-3:0], 1'b0};
    assign w_exp_n  = r_exp - {{(XW-1){1'b0}}, ~r_quo[Q-1]};
    assign w_sticky = ((w_qn & LOW_MASK) != '0) || (r_rem != '0);
    assign w_exp_r  = w_exp_n + {{(XW-1){1'b0}}, w_carry};

    result_rounder #(
        .MANTISSA_WIDTH  (MW),
        .ROUND_TO_NEAREST(ROUND_TO_NEAREST)
    ) u_rounder (
        .i_mant  (w_qn[Q-2:TRB+1]),
        .i_guard (w_qn[TRB]),
        .i_sticky(w_sticky),
        .o_mant  (w_rmant),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (in_valid) w_next = w_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (r_cnt == '0) w_next = S_NORM;
            S_NORM:   w_next = S_DONE;
            S_DONE:   if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
            r_out  <= '0;
            r_uf   <= 1'b0;
            r_of   <= 1'b0;
            r_inv  <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (in_valid) begin
                    r_sign <= w_sign;
                    r_div  <= {1'b1, b[MW-1:0]};
                    r_rem  <= {2'b01, a[MW-1:0]};
                    r_quo  <= '0;
                    r_cnt  <= CW'(Q);
                    r_exp  <= $signed({2'b00, a[W-2:MW]})
                            - $signed({2'b00, b[W-2:MW]}) + BIAS;
                    r_uf   <= 1'b0;
                    r_of   <= 1'b0;
                    r_inv  <= w_special && w_sp_inv;
                    r_dbz  <= w_special && w_sp_dbz;
                    if (w_special) r_out <= w_sp_out;
                end
                S_DIVIDE: if (r_cnt != '0) begin
                    r_rem <= {w_rem_sel, 1'b0};
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - 1'b1;
`ifdef FP_DIV_EARLY_EXIT_EN
                    if (w_ge && (w_rem_sel == '0)) begin
                        r_quo <= w_quo_nxt << (r_cnt - 1'b1);
                        r_cnt <= '0;
                    end
`endif
                end
                S_NORM: begin
                    if (w_exp_r <= 0) begin
                        r_out <= {r_sign, {(W-1){1'b0}}};
                        r_uf  <= 1'b1;
                    end else if (w_exp_r >= EXP_MAX) begin
                        r_out <= {r_sign, {EW{1'b1}}, {MW{1'b0}}};
                        r_of  <= 1'b1;
                    end else begin
                        r_out <= {r_sign, w_exp_r[EW-1:0], w_rmant};
                    end
                end
                default: ;
            endcase
        end
    end

    assign out                    = r_out;
    assign underflow_flag         = r_uf;
    assign overflow_flag          = r_of;
    assign invalid_operation_flag = r_inv;
    assign divide_by_zero_flag    = r_dbz;
endmodule

// File: tb/tb_floating_point_divider_seq.sv
// Directed bench for floating_point_divider_seq (binary32 defaults).
// Flags are compared as {underflow, overflow, invalid, divide_by_zero}.
module tb_floating_point_divider_seq;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, out;
    logic        uf, of, inv, dbz;
    int          n_tests = 0;
    int          n_fail  = 0;

    floating_point_divider_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .underflow_flag(uf), .overflow_flag(of),
        .invalid_operation_flag(inv), .divide_by_zero_flag(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and waits (bounded) for its result.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output logic [31:0] res, output logic [3:0] fl,
                          output int lat);
        @(negedge clk);
        a = ia; b = ib; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (!out_valid) begin
            $display("FAIL timeout %h/%h: no out_valid after %0d edges", ia, ib, lat);
            n_fail++;
        end
        res = out;
        fl  = {uf, of, inv, dbz};
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        n_tests++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got %b want 1", in_ready); n_fail++;
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid got %b want 0", out_valid); n_fail++;
        end
        n_tests++;
        if (out !== 32'h0) begin
            $display("FAIL reset_out got %h want 00000000", out); n_fail++;
        end
        n_tests++;
        if ({uf, of, inv, dbz} !== 4'b0) begin
            $display("FAIL reset_flags got %b want 0000", {uf, of, inv, dbz}); n_fail++;
        end
    endtask

    task automatic test_basic;
        logic [31:0] r; logic [3:0] f; int lat;
        run_op(32'h40C00000, 32'h40000000, r, f, lat);
        n_tests++;
        if (r !== 32'h40400000) begin
            $display("FAIL div_6_2 got %h want 40400000", r); n_fail++;
        end
        n_tests++;
        if (f !== 4'b0) begin
            $display("FAIL div_6_2_flags got %b want 0000", f); n_fail++;
        end
        n_tests++;
`ifdef FP_DIV_EARLY_EXIT_EN
        if (lat > 30 || lat < 1) begin
            $display("FAIL div_6_2_latency got %0d want <=30", lat); n_fail++;
        end
`else
        if (lat !== 30) begin
            $display("FAIL div_6_2_latency got %0d want 30", lat); n_fail++;
        end
`endif
    endtask

    task automatic test_normal;
        logic [31:0] va [4] = '{32'h3F800000, 32'h7F000000, 32'h00800000, 32'hC0C00000};
        logic [31:0] vb [4] = '{32'h40400000, 32'h3F000000, 32'h4B000000, 32'h40000000};
        logic [31:0] vo [4] = '{32'h3EAAAAAB, 32'h7F800000, 32'h00000000, 32'hC0400000};
        logic [3:0]  vf [4] = '{4'b0000, 4'b0100, 4'b1000, 4'b0000};
        logic [31:0] r; logic [3:0] f; int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], r, f, lat);
            n_tests++;
            if (r !== vo[i]) begin
                $display("FAIL normal_%0d %h/%h got %h want %h", i, va[i], vb[i], r, vo[i]);
                n_fail++;
            end
            n_tests++;
            if (f !== vf[i]) begin
                $display("FAIL normal_flags_%0d got %b want %b", i, f, vf[i]); n_fail++;
            end
        end
        n_tests++;
        if (lat !== 30) begin
            $display("FAIL normal_latency got %0d want 30", lat); n_fail++;
        end
    endtask

    task automatic test_specials;
        logic [31:0] va [10] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000,
                                 32'h7F800001, 32'h7FC00000, 32'h7F800000, 32'h40000000,
                                 32'h00000000, 32'hC0000000};
        logic [31:0] vb [10] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000,
                                 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h7F800000,
                                 32'h40000000, 32'h7F800000};
        logic [31:0] vo [10] = '{32'h7F800000, 32'hFF800000, 32'hFFC00000, 32'hFFC00000,
                                 32'hFFC00000, 32'hFFC00000, 32'h7F800000, 32'h00000000,
                                 32'h00000000, 32'h80000000};
        logic [3:0]  vf [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [31:0] r; logic [3:0] f; int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(va[i], vb[i], r, f, lat);
            n_tests++;
            if (r !== vo[i]) begin
                $display("FAIL special_%0d %h/%h got %h want %h", i, va[i], vb[i], r, vo[i]);
                n_fail++;
            end
            n_tests++;
            if (f !== vf[i]) begin
                $display("FAIL special_flags_%0d got %b want %b", i, f, vf[i]); n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        out_ready = 1'b0;
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h3F800000; b = 32'h40400000;
        n = 0;
        while (!out_valid && n < 100) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
                $display("FAIL bp_busy_in_ready got %b want 0 at %0d", in_ready, n); n_fail++;
            end
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out !== 32'h40400000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                $display("FAIL bp_hold_%0d out %h rdy %b vld %b want 40400000 0 1",
                         i, out, in_ready, out_valid);
                n_fail++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL bp_release rdy %b vld %b want 1 0", in_ready, out_valid); n_fail++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0) begin
            $display("FAIL bp_second_accept in_ready got %b want 0", in_ready); n_fail++;
        end
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (out !== 32'h3EAAAAAB || n !== 30) begin
            $display("FAIL bp_second got %h after %0d want 3EAAAAAB after 30", out, n);
            n_fail++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        logic [31:0] r; logic [3:0] f; int lat;
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL async_reset vld %b rdy %b want 0 1", out_valid, in_ready); n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h40C00000, 32'h40000000, r, f, lat);
        n_tests++;
        if (r !== 32'h40400000) begin
            $display("FAIL async_reset_rerun got %h want 40400000", r); n_fail++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_normal();
        test_specials();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
